// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double-dabble, one bit per clock).
// Produces an overflow flag and a leading-zero blanking mask alongside each result.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BIN_W-1:0]      BIN,
  output logic                  BUSY,
  output logic                  VALID,
  output logic [4*DIGITS-1:0]   BCDOUT,
  output logic                  OVF,
  output logic [DIGITS-1:0]     BLANK
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int AW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     adj;

  // Bit i set when digit i and every digit above it are zero; the ones digit is never blanked.
  function automatic logic [DIGITS-1:0] blank_of(input logic [AW-1:0] v);
    logic [DIGITS-1:0] b;
    logic              zero_hi;
    b       = '0;
    zero_hi = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_hi = zero_hi & (v[4*i +: 4] == 4'd0);
      b[i]    = zero_hi;
    end
    return b;
  endfunction

  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    blank_d  = blank_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          bin_d    = BIN;
          acc_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        acc_d    = {adj[AW-2:0], bin_q[BIN_W-1]};
        bin_d    = bin_q << 1;
        sticky_d = sticky_q | adj[AW-1];
        cnt_d    = cnt_q + 1'b1;
        // Final shift: publish directly from the next-state accumulator.
        if (cnt_q == CW'(BIN_W - 1)) begin
          bcd_d   = acc_d;
          ovf_d   = sticky_d;
          blank_d = blank_of(acc_d);
          valid_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      bin_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      blank_q  <= BLANK_RST;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      blank_q  <= blank_d;
      valid_q  <= valid_d;
    end
  end

  assign BUSY   = (state_q == S_CONV);
  assign VALID  = valid_q;
  assign BCDOUT = bcd_q;
  assign OVF    = ovf_q;
  assign BLANK  = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default 10-bit instance plus a 14-bit instance for overflow cases.
module tb_bin_to_bcd_seq;

  logic        CLK;
  logic        RST;
  logic        start10, start14;
  logic [9:0]  bin10;
  logic [13:0] bin14;
  logic        busy10, valid10, ovf10, busy14, valid14, ovf14;
  logic [15:0] bcd10, bcd14;
  logic [3:0]  blank10, blank14;

  logic        sel;
  logic        o_busy, o_valid, o_ovf;
  logic [15:0] o_bcd;
  logic [3:0]  o_blank;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_bcd [2];

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut10 (
    .CLK(CLK), .RST(RST), .START(start10), .BIN(bin10),
    .BUSY(busy10), .VALID(valid10), .BCDOUT(bcd10), .OVF(ovf10), .BLANK(blank10)
  );

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
    .CLK(CLK), .RST(RST), .START(start14), .BIN(bin14),
    .BUSY(busy14), .VALID(valid14), .BCDOUT(bcd14), .OVF(ovf14), .BLANK(blank14)
  );

  assign o_busy  = sel ? busy14  : busy10;
  assign o_valid = sel ? valid14 : valid10;
  assign o_bcd   = sel ? bcd14   : bcd10;
  assign o_ovf   = sel ? ovf14   : ovf10;
  assign o_blank = sel ? blank14 : blank10;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: decimal digits by repeated division; blanking from magnitude of the kept value.
  function automatic void model(input int unsigned v, output logic [15:0] bcd,
                                output logic ovf, output logic [3:0] blank);
    int unsigned r, m, p;
    r = v;
    bcd = '0;
    for (int i = 0; i < 4; i++) begin
      bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    ovf = (v >= 10000);
    m = v % 10000;
    blank = '0;
    p = 1;
    for (int i = 1; i < 4; i++) begin
      p = p * 10;
      blank[i] = (m < p);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  o_busy,  32'd0);
    chk({tag, "_valid"}, o_valid, 32'd0);
    chk({tag, "_bcd"},   o_bcd,   32'd0);
    chk({tag, "_ovf"},   o_ovf,   32'd0);
    chk({tag, "_blank"}, o_blank, 32'b1110);
  endtask

  task automatic convert(input logic s, input int unsigned v);
    logic [15:0] eb;
    logic        eo;
    logic [3:0]  ebl;
    int          busy_n;
    int          w;
    logic        got;
    w = s ? 14 : 10;
    model(v, eb, eo, ebl);
    @(negedge CLK);
    sel = s;
    if (s) begin start14 = 1'b1; bin14 = 14'(v); end
    else   begin start10 = 1'b1; bin10 = 10'(v); end
    @(posedge CLK);
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        start10 = 1'b0;
        start14 = 1'b0;
        bin10   = 10'($urandom);
        bin14   = 14'($urandom);
        chk("hold_during_conv", o_bcd, last_bcd[s]);
      end
      if (o_valid) begin
        got = 1'b1;
        chk("latency", k, w);
        chk("busy_cycles", busy_n, w);
        chk("busy_at_valid", o_busy, 32'd0);
        chk("bcd", o_bcd, eb);
        chk("ovf", o_ovf, eo);
        chk("blank", o_blank, ebl);
      end else if (o_busy) begin
        busy_n++;
      end
    end
    chk("valid_seen", got, 32'd1);
    last_bcd[s] = eb;
  endtask

  initial begin
    logic [15:0] eb;
    logic        eo;
    logic [3:0]  ebl;
    int unsigned hist[$];
    logic        exp_v;
    logic        seen;

    RST = 1'b1; start10 = 1'b0; start14 = 1'b0; bin10 = '0; bin14 = '0; sel = 1'b0;
    last_bcd[0] = '0; last_bcd[1] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("rst10");
    sel = 1'b1;
    check_reset_outputs("rst14");
    RST = 1'b0;

    convert(1'b0, 1023);
    convert(1'b0, 0);
    convert(1'b0, 7);
    convert(1'b0, 40);
    convert(1'b1, 16383);
    convert(1'b1, 9999);
    for (int n = 0; n < 30; n++) convert(1'b1, $urandom_range(0, 16383));

    // START held high, BIN changing every cycle: a result every 11 cycles.
    @(negedge CLK);
    sel = 1'b0;
    start10 = 1'b1;
    bin10 = 10'($urandom);
    for (int c = 0; c < 55; c++) begin
      @(posedge CLK);
      hist.push_back(int'(bin10));
      @(negedge CLK);
      exp_v = (c >= 10) && ((c - 10) % 11 == 0);
      chk("b2b_valid", o_valid, exp_v);
      if (exp_v) begin
        model(hist[c-10], eb, eo, ebl);
        chk("b2b_bcd", o_bcd, eb);
        chk("b2b_ovf", o_ovf, eo);
        last_bcd[0] = eb;
      end
      bin10 = 10'($urandom);
      if (c == 54) start10 = 1'b0;
    end

    // Reset in the middle of a conversion of 512.
    @(negedge CLK);
    start10 = 1'b1;
    bin10 = 10'd512;
    @(posedge CLK);
    @(negedge CLK);
    start10 = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_outputs("midrst");
    RST = 1'b0;
    last_bcd[0] = '0;
    last_bcd[1] = '0;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK);
      if (o_valid) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 32'd0);
    convert(1'b0, 512);

    for (int v = 0; v < 1024; v++) convert(1'b0, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
